// File: rtl/capture_scheduler.sv
// capture_scheduler: averages 2^AVG_LOG2 ADC samples per trigger, strobes the result and drives a hysteretic alarm
module capture_scheduler #(
  parameter int          SAMPLE_PERIOD = 5_000_000,
  parameter int          AVG_LOG2      = 2,
  parameter int          TIMEOUT       = 1_000_000,
  parameter logic [12:0] ALARM_NEAR    = 13'd1000,
  parameter logic [12:0] ALARM_HYST    = 13'd50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mode_auto,
  input  logic        capture_req,
  input  logic        adc_valid,
  input  logic [12:0] distance_in,
  output logic        write_enable,
  output logic [12:0] avg_out,
  output logic        busy,
  output logic        alarm,
  output logic        error
);
  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int AW = 13 + AVG_LOG2;

  typedef enum logic [1:0] {IDLE, ACCUM, LOAD} state_t;
  state_t state, state_n;

  logic [PW-1:0]       tick_cnt;
  logic [TW-1:0]       to_cnt;
  logic [AVG_LOG2-1:0] smp_cnt;
  logic [AW-1:0]       acc, sum;
  logic [12:0]         avg_n;
  logic [13:0]         clr_lvl;
  logic                pending, tick, trigger, last, expire;

  assign tick         = mode_auto && tick_cnt == PW'(SAMPLE_PERIOD - 1);
  assign trigger      = capture_req || tick;
  assign sum          = acc + AW'(distance_in);
  assign avg_n        = sum[AW-1:AVG_LOG2];
  assign clr_lvl      = {1'b0, ALARM_NEAR} + {1'b0, ALARM_HYST};
  assign last         = adc_valid && &smp_cnt;
  assign expire       = !adc_valid && to_cnt == TW'(TIMEOUT - 1);
  assign busy         = state != IDLE;
  assign write_enable = state == LOAD;

  // next state: IDLE waits for a trigger, ACCUM ends on the last sample or a timeout, LOAD lasts one cycle
  always_comb begin
    state_n = state == IDLE  ? ((trigger || pending) ? ACCUM : IDLE) :
              state == ACCUM ? (last ? LOAD : expire ? IDLE : ACCUM) : IDLE;
  end

  // state register
  always_ff @(posedge clk) begin
    state <= reset ? IDLE : state_n;
  end

  // auto tick counter, parked at zero while manual mode is selected
  always_ff @(posedge clk) begin
    if (reset || !mode_auto || tick) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + 1'b1;
  end

  // accumulation, pending trigger, timeout and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
      acc     <= '0;
      smp_cnt <= '0;
      to_cnt  <= '0;
      avg_out <= '0;
      alarm   <= 1'b0;
      error   <= 1'b0;
    end else begin
      if (state == IDLE && state_n == ACCUM) begin
        acc     <= '0;
        smp_cnt <= '0;
        to_cnt  <= '0;
        pending <= 1'b0;
      end
      if (state != IDLE && trigger) pending <= 1'b1;
      if (state == ACCUM) begin
        if (adc_valid) begin
          acc     <= sum;
          smp_cnt <= smp_cnt + 1'b1;
          to_cnt  <= '0;
        end else to_cnt <= to_cnt + 1'b1;
        if (last) begin
          avg_out <= avg_n;
          alarm   <= avg_n < ALARM_NEAR ? 1'b1 : {1'b0, avg_n} >= clr_lvl ? 1'b0 : alarm;
          error   <= 1'b0;
        end
        if (expire) error <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_capture_scheduler.sv
// tb_capture_scheduler: randomized and directed stimulus checked every cycle against a behavioural model
module tb_capture_scheduler;
  localparam int SP = 20;
  localparam int TO = 16;
  localparam int N  = 4;

  logic        clk = 1'b0, rst = 1'b1, mode = 1'b0, req = 1'b0, valid = 1'b0;
  logic [12:0] din = '0;
  logic        we, busy, alarm, err;
  logic [12:0] avg;

  capture_scheduler #(.SAMPLE_PERIOD(SP), .AVG_LOG2(2), .TIMEOUT(TO),
                      .ALARM_NEAR(13'd1000), .ALARM_HYST(13'd50)) dut (
    .clk(clk), .reset(rst), .mode_auto(mode), .capture_req(req), .adc_valid(valid),
    .distance_in(din), .write_enable(we), .avg_out(avg), .busy(busy), .alarm(alarm), .error(err)
  );

  always #5 clk = ~clk;

  int cmp_n = 0, cmp_bad = 0, lit_n = 0, lit_bad = 0, we_seen = 0;
  bit chk_on = 1'b0;

  bit m_cap = 0, m_load = 0, m_pend = 0, m_alarm = 0, m_err = 0;
  int m_avg = 0, m_tc = 0, m_gap = 0;
  int q[$];

  // model: a capture collects N samples in a queue and reports their truncated mean
  always @(posedge clk) begin : model
    bit trig;
    int s;
    if (rst) begin
      m_cap = 0; m_load = 0; m_pend = 0; m_alarm = 0; m_err = 0;
      m_avg = 0; m_tc = 0; m_gap = 0;
      q.delete();
    end else begin
      trig = req || (mode && m_tc == SP - 1);
      m_tc = (mode && m_tc != SP - 1) ? m_tc + 1 : 0;
      if (m_load) begin
        m_load = 0;
        if (trig) m_pend = 1;
      end else if (m_cap) begin
        if (trig) m_pend = 1;
        if (valid) begin
          q.push_back(int'(din));
          m_gap = 0;
          if (q.size() == N) begin
            s = 0;
            foreach (q[i]) s += q[i];
            m_avg = s / N;
            if (m_avg < 1000) m_alarm = 1;
            else if (m_avg >= 1050) m_alarm = 0;
            m_err = 0;
            m_cap = 0;
            m_load = 1;
          end
        end else if (m_gap == TO - 1) begin
          m_err = 1;
          m_cap = 0;
        end else m_gap++;
      end else if (trig || m_pend) begin
        m_cap = 1; m_pend = 0; m_gap = 0;
        q.delete();
      end
    end
  end

  // per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_on) begin
      cmp_n++;
      if ({we, busy, alarm, err} !== {m_load, m_cap || m_load, m_alarm, m_err} || avg !== 13'(m_avg)) begin
        cmp_bad++;
        $display("FAIL cycle t=%0t dut we=%b busy=%b alarm=%b err=%b avg=%0d model we=%b busy=%b alarm=%b err=%b avg=%0d",
                 $time, we, busy, alarm, err, avg, m_load, m_cap || m_load, m_alarm, m_err, m_avg);
      end
    end
  end

  task automatic drv(input bit r, input bit v, input int d);
    @(negedge clk);
    if (we === 1'b1) we_seen++;
    req = r; valid = v; din = 13'(d);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    lit_n++;
    if (act != exp) begin
      lit_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic capture(input int a, input int b, input int c, input int d);
    drv(1, 0, 0);
    drv(0, 1, a);
    drv(0, 1, b);
    drv(0, 1, c);
    drv(0, 1, d);
    drv(0, 0, 0);
  endtask

  initial begin
    int dens;
    repeat (3) drv(0, 0, 0);
    chk_on = 1'b1;
    chk("reset_outputs", int'({we, busy, alarm, err, avg}), 0);
    rst = 1'b0;
    repeat (6) drv(0, 0, 0);

    capture(100, 200, 300, 401);
    chk("manual_we", int'(we), 1);
    chk("manual_avg", int'(avg), 250);
    chk("manual_alarm", int'(alarm), 1);
    drv(0, 0, 0);
    chk("manual_idle", int'({we, busy}), 0);

    capture(900, 900, 900, 900);    chk("hyst_900", int'(alarm), 1);
    capture(1020, 1020, 1020, 1020); chk("hyst_1020a", int'(alarm), 1);
    capture(1060, 1060, 1060, 1060); chk("hyst_1060", int'(alarm), 0);
    capture(1020, 1020, 1020, 1020); chk("hyst_1020b", int'(alarm), 0);
    capture(999, 999, 999, 999);    chk("hyst_999", int'(alarm), 1);
    capture(1050, 1050, 1050, 1050); chk("hyst_1050", int'(alarm), 0);

    we_seen = 0;
    drv(1, 0, 0);
    drv(1, 1, 10);
    drv(0, 1, 20);
    drv(1, 1, 30);
    drv(1, 1, 40);
    repeat (12) drv(0, 1, 50);
    repeat (6) drv(0, 0, 0);
    chk("pending_strobes", we_seen, 2);
    chk("pending_avg", int'(avg), 50);

    drv(1, 0, 0);
    drv(0, 1, 500);
    drv(0, 1, 600);
    repeat (16) drv(0, 0, 0);
    chk("timeout_before", int'({busy, err}), 2);
    drv(0, 0, 0);
    chk("timeout_err", int'(err), 1);
    chk("timeout_busy", int'(busy), 0);
    chk("timeout_avg", int'(avg), 50);
    capture(1000, 1000, 1000, 1003);
    chk("err_clear", int'(err), 0);
    chk("err_clear_avg", int'(avg), 1000);

    drv(1, 0, 0);
    drv(0, 1, 3000);
    drv(0, 1, 3000);
    drv(0, 0, 0);
    rst = 1'b1;
    drv(0, 0, 0);
    rst = 1'b0;
    chk("reset_mid", int'({we, busy, alarm, err, avg}), 0);
    capture(2000, 2000, 2000, 2004);
    chk("post_reset_avg", int'(avg), 2001);

    drv(0, 0, 0);
    rst = 1'b1; mode = 1'b1;
    drv(0, 0, 0);
    rst = 1'b0;
    we_seen = 0;
    repeat (110) drv(0, 1, $urandom_range(0, 8191));
    chk("auto_strobes", we_seen, 5);
    mode = 1'b0;
    repeat (10) drv(0, 1, $urandom_range(0, 8191));
    we_seen = 0;
    repeat (60) drv(0, 1, $urandom_range(0, 8191));
    chk("auto_stop", we_seen, 0);

    dens = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 300 == 0) dens = (i / 300) % 3 == 0 ? 1 : (i / 300) % 3 == 1 ? 3 : 25;
      drv($urandom_range(0, 11) == 0, $urandom_range(1, dens) == 1,
          $urandom_range(0, 1) ? $urandom_range(900, 1100) : $urandom_range(0, 8191));
      if ($urandom_range(0, 199) == 0) mode = ~mode;
      rst = $urandom_range(0, 399) == 0;
    end
    drv(0, 0, 0);
    rst = 1'b0;
    drv(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", cmp_n + lit_n, cmp_bad + lit_bad);
    $finish;
  end
endmodule

// File: doc/capture_scheduler.md
# capture_scheduler

- Sequences distance-sample capture for the display/alarm datapath.
- Replaces the raw debounced-button write strobe with a scheduler that averages 2^AVG_LOG2 ADC distance samples and issues a single-cycle write strobe to the display storage register.
- Triggers come from either a manual request or a periodic auto tick.
- Also drives a hysteretic proximity alarm consumed by the buzzer/flash converters.

## Interface
Parameters:
- SAMPLE_PERIOD, 5_000_000: auto-mode tick period in clk cycles (100 ms at 50 MHz); minimum 2.
- AVG_LOG2, 2: log2 of samples averaged per capture (1..4).
- TIMEOUT, 1_000_000: max cycles between accepted samples before a capture aborts.
- ALARM_NEAR, 13'd1000: alarm asserts when the average is below this.
- ALARM_HYST, 13'd50: alarm clears when the average is ≥ ALARM_NEAR+ALARM_HYST.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high.
- mode_auto, in, 1: already-synchronized level; 1 = periodic capture, 0 = manual only.
- capture_req, in, 1: single-cycle pulse from the debouncer.
- adc_valid, in, 1: single-cycle pulse when distance_in holds a new sample.
- distance_in, in, 13: distance sample.
- write_enable, out, 1: one-cycle strobe to the storage register.
- avg_out, out, 13: averaged distance, stable between strobes.
- busy, out, 1: high in ACCUM and LOAD.
- alarm, out, 1: proximity alarm.
- error, out, 1: sticky timeout flag.

## Operation
- Reset values:
  - Outputs all 0.
  - State IDLE; pending, tick counter, accumulator and sample count cleared.
- Tick counter:
  - Counts only while mode_auto=1; held at 0 while mode_auto=0.
  - Tick pulses for one cycle when the count reaches SAMPLE_PERIOD-1, then the count wraps to 0.
- Trigger = capture_req OR tick.
- States:
  - IDLE: on trigger or pending=1, go to ACCUM; clear accumulator, sample count and timeout counter; clear pending.
  - ACCUM: each cycle with adc_valid=1, add distance_in to the accumulator, increment the sample count and clear the timeout counter. When the sample just accepted is the 2^AVG_LOG2-th, go to LOAD. If the timeout counter reaches TIMEOUT-1 with no sample, set error and go to IDLE. In that abort case avg_out, write_enable and alarm are untouched.
  - LOAD: write_enable=1 for exactly this cycle; go to IDLE.
- Arithmetic:
  - Accumulator is 13+AVG_LOG2 bits, unsigned, no overflow possible.
  - avg_out = accumulator >> AVG_LOG2 (truncation).
- Triggers arriving while busy set pending (depth 1; further triggers are merged). A trigger arriving in the same cycle IDLE exits is absorbed and does not set pending.
- adc_valid in IDLE or LOAD is ignored.
- Changing mode_auto mid-capture does not abort the capture; the tick counter resets as specified.
- Alarm, evaluated on the new avg_out at LOAD:
  - avg < ALARM_NEAR sets it.
  - avg ≥ ALARM_NEAR+ALARM_HYST clears it.
  - Otherwise it holds.
- error clears on the next successful LOAD, or on reset.
- reset mid-capture discards the partial accumulation and any pending trigger.

## Timing
- Trigger in cycle t (IDLE) → busy=1 and ACCUM from t+1.
- A sample in cycle t+1 is accepted.
- Last sample accepted in cycle s → write_enable=1, new avg_out and updated alarm all visible in cycle s+1 (LOAD). IDLE and busy=0 in s+2.
- Pending trigger → ACCUM in s+3 (one IDLE cycle).
- Minimum capture latency, trigger to strobe: 2^AVG_LOG2+1 cycles with back-to-back adc_valid.
- Timeout abort: error=1 and busy=0 in the cycle after the timeout counter reaches TIMEOUT-1.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
Bench parameters: SAMPLE_PERIOD=20, AVG_LOG2=2, TIMEOUT=16, ALARM_NEAR=1000, ALARM_HYST=50.

- Manual average:
  - Stimulus: mode_auto=0; capture_req at cycle 10; adc_valid on cycles 11–14 with distances 100, 200, 300, 401.
  - Response: write_enable only at cycle 15; avg_out=250; busy high 11–15; alarm=1.
- Alarm hysteresis:
  - Stimulus: successive captures averaging 900, 1020, 1060, 1020.
  - Response: alarm 1, 1, 0, 0.
- Auto mode:
  - Stimulus: mode_auto=1 from reset release; adc_valid every cycle.
  - Response: write_enable exactly once per 20 cycles; mode_auto→0 stops further strobes after any in-flight capture completes.
- Pending merge:
  - Stimulus: three capture_req pulses during one ACCUM.
  - Response: exactly one extra capture follows, starting one IDLE cycle after the first LOAD; two strobes total.
- Timeout:
  - Stimulus: capture_req; two samples; then no adc_valid.
  - Response: error=1 and busy=0 after 16 idle cycles; no write_enable; avg_out unchanged; error clears at the next successful LOAD.
- Reset mid-capture:
  - Stimulus: reset asserted for one cycle after two samples.
  - Response: next cycle all outputs 0, state IDLE; a new capture averages only post-reset samples.
